// File: rtl/cirno_pkg.sv
// Shared types and encodings for the decoder pipeline: instruction-type and
// funct constants, FSM state encoding and the raw decoded bundle.
// The bundle stores register fields at their native 2-bit width and the
// immediate at its native 6-bit width; the top zero-extends both on output.
package cirno_pkg;

  // inst_type encodings
  localparam logic [2:0] TYPE_ALU   = 3'd1;
  localparam logic [2:0] TYPE_NOBR  = 3'd2;
  localparam logic [2:0] TYPE_BRREG = 3'd3;
  localparam logic [2:0] TYPE_MOV   = 3'd4;
  localparam logic [2:0] TYPE_STORE = 3'd5;
  localparam logic [2:0] TYPE_LOAD  = 3'd6;

  // funct encodings produced by fixed-form instructions
  localparam logic [3:0] FUNCT_AND      = 4'b0011;
  localparam logic [3:0] FUNCT_SHIFT_S1 = 4'b0111;
  localparam logic [3:0] FUNCT_SHIFT_S0 = 4'b1110;
  localparam logic [3:0] FUNCT_INCR     = 4'b0101;

  // opcode field values of the generic 0ffffxxyy form
  localparam logic [3:0] OPC_STORE = 4'b1001;
  localparam logic [3:0] OPC_LOAD  = 4'b1000;
  localparam logic [3:0] OPC_MV    = 4'b0111;

  localparam int SQ_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // is_halt marks a bundle that must park the pipe once it has been taken
  typedef struct packed {
    logic [1:0] r1;
    logic [1:0] r2;
    logic [2:0] inst_type;
    logic [3:0] funct;
    logic [5:0] imm;
    logic       branch;
    logic       branchi;
    logic       reg_hi_en;
    logic       reg_lo_en;
    logic       reg_readx_en;
    logic       reg_ready_en;
    logic       reg_swap_en;
    logic       y_is_imm;
    logic       illegal;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder (first match wins, all flags
// default to 0). Build option DECODER_ILLEGAL_TRAP_EN: when defined, the
// 00000001x encodings are flagged illegal and trap like halt; otherwise
// they decode as a plain nop.
module decode_comb
  import cirno_pkg::*;
(
  input  logic [8:0] inst,
  input  logic       cmp,
  output dec_t       dec
);

  // Priority decode of the 9-bit instruction word
  always_comb begin
    dec = '0;
    if (inst[8:6] == 3'b111) begin                // jmpi
      dec.inst_type = TYPE_NOBR;
      dec.branchi   = 1'b1;
      dec.imm       = inst[5:0];
    end else if (inst[8:6] == 3'b101) begin       // movhi
      dec.inst_type = TYPE_MOV;
      dec.reg_hi_en = 1'b1;
      dec.r1        = inst[5:4];
      dec.imm       = {2'b00, inst[3:0]};
    end else if (inst[8:6] == 3'b100) begin       // movli
      dec.inst_type = TYPE_MOV;
      dec.reg_lo_en = 1'b1;
      dec.r1        = inst[5:4];
      dec.imm       = {2'b00, inst[3:0]};
    end else if (inst[8:6] == 3'b110) begin       // andi
      dec.inst_type    = TYPE_ALU;
      dec.funct        = FUNCT_AND;
      dec.reg_readx_en = 1'b1;
      dec.y_is_imm     = 1'b1;
      dec.r1           = inst[5:4];
      dec.imm          = {2'b00, inst[3:0]};
    end else if (inst[8:6] == 3'b011) begin       // shift
      dec.inst_type    = TYPE_ALU;
      dec.funct        = inst[5] ? FUNCT_SHIFT_S1 : FUNCT_SHIFT_S0;
      dec.reg_readx_en = 1'b1;
      dec.y_is_imm     = 1'b1;
      dec.r1           = inst[4:3];
      dec.imm          = {3'b000, inst[2:0]};
    end else if (inst[8:4] == 5'b01011) begin     // beqi: only branches when cmp
      dec.inst_type = TYPE_NOBR;
      if (cmp) begin
        dec.branchi = 1'b1;
        dec.imm     = {2'b00, inst[3:0]};
      end
    end else if (inst[8:4] == 5'b00000) begin     // short-form group
      dec.inst_type = TYPE_NOBR;
      if (inst[3:0] == 4'b0000) begin             // nop
        dec.inst_type = TYPE_NOBR;
      end else if (inst[3:0] == 4'b0001) begin    // halt
        dec.is_halt = 1'b1;
      end else if (inst[3:2] == 2'b11) begin      // incr
        dec.inst_type    = TYPE_ALU;
        dec.funct        = FUNCT_INCR;
        dec.imm          = 6'd1;
        dec.y_is_imm     = 1'b1;
        dec.reg_readx_en = 1'b1;
        dec.r1           = inst[1:0];
      end else if (inst[3:2] == 2'b10) begin      // jmp
        dec.inst_type    = TYPE_BRREG;
        dec.branch       = 1'b1;
        dec.reg_readx_en = 1'b1;
        dec.r1           = inst[1:0];
      end else if (inst[3:2] == 2'b01) begin      // beq
        dec.reg_readx_en = 1'b1;
        dec.r1           = inst[1:0];
        if (cmp) begin
          dec.inst_type = TYPE_BRREG;
          dec.branch    = 1'b1;
        end
      end else begin                              // 00000001x
`ifdef DECODER_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
        dec.is_halt = 1'b1;
`else
        dec.illegal = 1'b0;
`endif
      end
    end else begin                                // generic 0ffffxxyy
      dec.r1           = inst[3:2];
      dec.r2           = inst[1:0];
      dec.reg_readx_en = 1'b1;
      dec.reg_ready_en = 1'b1;
      case (inst[7:4])
        OPC_STORE: dec.inst_type = TYPE_STORE;
        OPC_LOAD:  dec.inst_type = TYPE_LOAD;
        OPC_MV: begin
          dec.inst_type   = TYPE_MOV;
          dec.reg_swap_en = 1'b1;
        end
        default: begin
          dec.inst_type = TYPE_ALU;
          dec.funct     = inst[7:4];
        end
      endcase
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Single-stage decode pipeline: valid/ready input, one output register,
// and a RUN/SQUASH/HALTED controller. Build option DECODER_ILLEGAL_TRAP_EN
// (handled in decode_comb) makes illegal encodings trap like halt.
//
// Handshake: a transfer happens on a cycle where valid && ready are both
// high at the rising clk edge; valid, once raised, holds its payload
// stable until that transfer; ready may change freely.
module decoder_pipe
  import cirno_pkg::*;
#(
  parameter int RA_W     = 2,
  parameter int IMM_W    = 6,
  parameter int SQUASH_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        inst,
  input  logic              cmp,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              resume,
  output logic [RA_W-1:0]   r1,
  output logic [RA_W-1:0]   r2,
  output logic [2:0]        inst_type,
  output logic [3:0]        funct,
  output logic [IMM_W-1:0]  immediate,
  output logic              branch,
  output logic              branchi,
  output logic              reg_hi_en,
  output logic              reg_lo_en,
  output logic              reg_readx_en,
  output logic              reg_ready_en,
  output logic              reg_swap_en,
  output logic              y_is_imm,
  output logic              halted,
  output logic              illegal,
  output logic [1:0]        dbg_state
);

  state_t              state_q, state_d;
  logic [SQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  dec_t                bundle_q, bundle_d;
  dec_t                dec;
  logic                accept;
  logic                halt_pending;

  decode_comb u_decode (
    .inst (inst),
    .cmp  (cmp),
    .dec  (dec)
  );

  // A halting bundle still waiting for its output handshake blocks new input,
  // so nothing slips in on the same edge the pipe parks.
  assign halt_pending = out_valid_q && bundle_q.is_halt;
  assign in_ready     = (state_q == ST_SQUASH) ||
                        ((state_q == ST_RUN) && !halt_pending &&
                         (!out_valid_q || out_ready));
  assign accept       = in_valid && in_ready;

  // Next-state, squash counter and output-register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (bundle_q.is_halt) begin
        state_d = ST_HALTED;
      end
    end
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          bundle_d    = dec;
          if ((dec.branch || dec.branchi) && (SQUASH_N > 0)) begin
            state_d = ST_SQUASH;
            cnt_d   = SQ_CNT_W'(SQUASH_N);
          end
        end
      end
      ST_SQUASH: begin
        // wrong-path words are consumed and discarded, halts included
        if (accept) begin
          if (cnt_q <= SQ_CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - SQ_CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign r1           = RA_W'(bundle_q.r1);
  assign r2           = RA_W'(bundle_q.r2);
  assign inst_type    = bundle_q.inst_type;
  assign funct        = bundle_q.funct;
  assign immediate    = IMM_W'(bundle_q.imm);
  assign branch       = bundle_q.branch;
  assign branchi      = bundle_q.branchi;
  assign reg_hi_en    = bundle_q.reg_hi_en;
  assign reg_lo_en    = bundle_q.reg_lo_en;
  assign reg_readx_en = bundle_q.reg_readx_en;
  assign reg_ready_en = bundle_q.reg_ready_en;
  assign reg_swap_en  = bundle_q.reg_swap_en;
  assign y_is_imm     = bundle_q.y_is_imm;
  assign illegal      = bundle_q.illegal;
  assign halted       = (state_q == ST_HALTED);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe (default parameters, SQUASH_N=2).
// Honours DECODER_ILLEGAL_TRAP_EN so the illegal-encoding scenario matches
// whichever build is compiled.
module tb_decoder_pipe;

  localparam int W = 26;
  localparam logic [8:0] FL_BR = 9'b100000000;
  localparam logic [8:0] FL_BRI = 9'b010000000;
  localparam logic [8:0] FL_HI = 9'b001000000;
  localparam logic [8:0] FL_LO = 9'b000100000;
  localparam logic [8:0] FL_RX = 9'b000010000;
  localparam logic [8:0] FL_RY = 9'b000001000;
  localparam logic [8:0] FL_SW = 9'b000000100;
  localparam logic [8:0] FL_YI = 9'b000000010;
  localparam logic [8:0] FL_IL = 9'b000000001;
  localparam int NT = 13;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, cmp, out_valid, out_ready, resume;
  logic [8:0] inst;
  logic [1:0] r1, r2, dbg_state;
  logic [2:0] inst_type;
  logic [3:0] funct;
  logic [5:0] immediate;
  logic branch, branchi, reg_hi_en, reg_lo_en, reg_readx_en, reg_ready_en;
  logic reg_swap_en, y_is_imm, halted, illegal;
  logic [W-1:0] dut_vec;

  int checks = 0;
  int failures = 0;
  logic rand_bp = 1'b0;
  logic [W-1:0] exp_q[$];

  logic [8:0]   tbl_inst[NT];
  logic         tbl_cmp[NT];
  logic [W-1:0] tbl_exp[NT];
  logic [8:0]   br_inst[3];
  logic         br_cmp[3];
  logic [W-1:0] br_exp[3];

  decoder_pipe #(.RA_W(2), .IMM_W(6), .SQUASH_N(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .cmp(cmp), .out_valid(out_valid), .out_ready(out_ready),
    .resume(resume), .r1(r1), .r2(r2), .inst_type(inst_type), .funct(funct),
    .immediate(immediate), .branch(branch), .branchi(branchi),
    .reg_hi_en(reg_hi_en), .reg_lo_en(reg_lo_en), .reg_readx_en(reg_readx_en),
    .reg_ready_en(reg_ready_en), .reg_swap_en(reg_swap_en), .y_is_imm(y_is_imm),
    .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
  );

  assign dut_vec = {inst_type, funct, r1, r2, immediate, branch, branchi,
                    reg_hi_en, reg_lo_en, reg_readx_en, reg_ready_en,
                    reg_swap_en, y_is_imm, illegal};

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // random output backpressure, active only during the stream test
  always @(posedge clk) begin
    if (rand_bp) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard: compare each output handshake against the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got=%h required=none", dut_vec);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dut_vec !== e) begin
          failures++;
          $display("FAIL out_bundle got=%h required=%h", dut_vec, e);
        end
      end
    end
  end

  function automatic logic [W-1:0] ex(input logic [2:0] t, input logic [3:0] f,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [5:0] im, input logic [8:0] fl);
    return {t, f, a, b, im, fl};
  endfunction

  task automatic init_table();
    tbl_inst[0]  = 9'b110011010; tbl_exp[0]  = ex(3'd1, 4'b0011, 2'd1, 2'd0, 6'd10, FL_RX | FL_YI);
    tbl_inst[1]  = 9'b101100111; tbl_exp[1]  = ex(3'd4, 4'b0000, 2'd2, 2'd0, 6'd7,  FL_HI);
    tbl_inst[2]  = 9'b100011100; tbl_exp[2]  = ex(3'd4, 4'b0000, 2'd1, 2'd0, 6'd12, FL_LO);
    tbl_inst[3]  = 9'b011110101; tbl_exp[3]  = ex(3'd1, 4'b0111, 2'd2, 2'd0, 6'd5,  FL_RX | FL_YI);
    tbl_inst[4]  = 9'b011001011; tbl_exp[4]  = ex(3'd1, 4'b1110, 2'd1, 2'd0, 6'd3,  FL_RX | FL_YI);
    tbl_inst[5]  = 9'b010011101; tbl_exp[5]  = ex(3'd5, 4'b0000, 2'd3, 2'd1, 6'd0,  FL_RX | FL_RY);
    tbl_inst[6]  = 9'b010001011; tbl_exp[6]  = ex(3'd6, 4'b0000, 2'd2, 2'd3, 6'd0,  FL_RX | FL_RY);
    tbl_inst[7]  = 9'b001110110; tbl_exp[7]  = ex(3'd4, 4'b0000, 2'd1, 2'd2, 6'd0,  FL_RX | FL_RY | FL_SW);
    tbl_inst[8]  = 9'b000010110; tbl_exp[8]  = ex(3'd1, 4'b0001, 2'd1, 2'd2, 6'd0,  FL_RX | FL_RY);
    tbl_inst[9]  = 9'b000001110; tbl_exp[9]  = ex(3'd1, 4'b0101, 2'd2, 2'd0, 6'd1,  FL_RX | FL_YI);
    tbl_inst[10] = 9'b000000000; tbl_exp[10] = ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd0,  9'd0);
    tbl_inst[11] = 9'b010110110; tbl_exp[11] = ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd0,  9'd0);
    tbl_inst[12] = 9'b000000111; tbl_exp[12] = ex(3'd2, 4'b0000, 2'd3, 2'd0, 6'd0,  FL_RX);
    for (int i = 0; i < NT; i++) tbl_cmp[i] = 1'b0;
    br_inst[0] = 9'b000001001; br_cmp[0] = 1'b1; br_exp[0] = ex(3'd3, 4'b0000, 2'd1, 2'd0, 6'd0, FL_BR | FL_RX);
    br_inst[1] = 9'b111000101; br_cmp[1] = 1'b0; br_exp[1] = ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd5, FL_BRI);
    br_inst[2] = 9'b010111001; br_cmp[2] = 1'b1; br_exp[2] = ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd9, FL_BRI);
  endtask

  // driver: present one word and hold it until accepted (bounded)
  task automatic send(input logic [8:0] i, input logic c);
    int n = 0;
    in_valid = 1'b1;
    inst = i;
    cmp = c;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout inst=%b in_ready=%b required=1", i, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, halted, illegal} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000", {out_valid, halted, illegal});
    end
    checks++;
    if (dut_vec !== '0) begin
      failures++;
      $display("FAIL reset_bundle got=%h required=0", dut_vec);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d required=0", dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_decode();
    // first word alone: latency-1 out_valid
    exp_q.push_back(tbl_exp[0]);
    send(tbl_inst[0], tbl_cmp[0]);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL andi_latency out_valid=%b required=1", out_valid);
    end
    wait_drain("andi");
    for (int i = 1; i < NT; i++) begin
      exp_q.push_back(tbl_exp[i]);
      send(tbl_inst[i], tbl_cmp[i]);
    end
    wait_drain("decode");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    exp_q.push_back(tbl_exp[8]);
    send(tbl_inst[8], 1'b0);
    in_valid = 1'b1;
    inst = tbl_inst[1];
    cmp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_vec !== tbl_exp[8]) begin
        failures++;
        $display("FAIL stall_hold ov=%b rdy=%b got=%h required ov=1 rdy=0 %h",
                 out_valid, in_ready, dut_vec, tbl_exp[8]);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("stall");
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_second_accept out_valid=%b required=0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_squash();
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(br_exp[b]);
      send(br_inst[b], br_cmp[b]);
      resume = (b == 0);
      send((b == 1) ? 9'b000000001 : tbl_inst[8], 1'b0);
      send(tbl_inst[5], 1'b0);
      resume = 1'b0;
      exp_q.push_back(tbl_exp[1]);
      send(tbl_inst[1], 1'b0);
      wait_drain("squash");
      @(negedge clk);
      checks++;
      if (halted !== 1'b0 || dbg_state !== 2'd0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL squash_after_%0d halted=%b state=%0d ov=%b required 0 0 0",
                 b, halted, dbg_state, out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    exp_q.push_back(ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd0, 9'd0));
    send(9'b000000001, 1'b0);
    wait_drain("halt");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d halted=%b in_ready=%b required 1 0", k, halted, in_ready);
      end
    end
    @(posedge clk);
    #1;
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume in_ready=%b halted=%b required 1 0", in_ready, halted);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(tbl_exp[2]);
    send(tbl_inst[2], 1'b0);
    wait_drain("resume");
  endtask

  task automatic test_illegal();
`ifdef DECODER_ILLEGAL_TRAP_EN
    exp_q.push_back(ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd0, FL_IL));
    send(9'b000000010, 1'b0);
    wait_drain("illegal");
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL illegal_trap halted=%b state=%0d required 1 2", halted, dbg_state);
    end
    @(posedge clk);
    #1;
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
`else
    exp_q.push_back(ex(3'd2, 4'b0000, 2'd0, 2'd0, 6'd0, 9'd0));
    send(9'b000000010, 1'b0);
    wait_drain("illegal");
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || dbg_state !== 2'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL illegal_nop halted=%b state=%0d rdy=%b required 0 0 1",
               halted, dbg_state, in_ready);
    end
    @(posedge clk);
    #1;
`endif
    exp_q.push_back(tbl_exp[3]);
    send(tbl_inst[3], 1'b0);
    wait_drain("post_illegal");
  endtask

  task automatic test_reset_squash();
    out_ready = 1'b0;
    send(br_inst[1], br_cmp[1]);   // branch bundle left pending, then dropped
    send(tbl_inst[8], 1'b0);       // wrong-path word consumed
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset state=%0d ov=%b required 1 1", dbg_state, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_squash_reset ov=%b state=%0d rdy=%b required 0 0 1",
               out_valid, dbg_state, in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(tbl_exp[2]);
    send(tbl_inst[2], 1'b0);
    wait_drain("post_reset");
  endtask

  task automatic test_back_to_back();
    rand_bp = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = $urandom_range(0, NT - 1);
      exp_q.push_back(tbl_exp[idx]);
      send(tbl_inst[idx], tbl_cmp[idx]);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    wait_drain("stream");
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    inst = '0;
    cmp = 1'b0;
    out_ready = 1'b1;
    resume = 1'b0;
    init_table();
    test_reset();
    test_decode();
    test_backpressure();
    test_squash();
    test_halt();
    test_illegal();
    test_reset_squash();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
